// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Front end of the multi-cycle core. Owns the PC and the 4-phase
// instruction-cycle counter (IF, ID, EX, WB) that paces the later stages.
// Each instruction is fetched over a req/ack port. The execute-stage redirect
// is consumed in WB. A fetch timeout or a misaligned jump target halts the
// sequencer until reset.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   inst_req/inst_addr  fetch request and address (address is always pc)
//   inst_ack/inst_rdata memory accept; read data is valid in the ack cycle
//   pc_jmp/pc_jmpaddr   registered redirect from execute, valid in WB
//   pc, inst            PC and latched instruction word of the instruction in flight
//   instcycle_cnt_val   phase 0=IF 1=ID 2=EX 3=WB
//   inst_commit         one-cycle pulse in WB of every retired instruction
//   halted, err_code    sticky halt flag; 00 none, 01 timeout, 10 misaligned jump
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC      = 64'h0000_0000_8000_0000,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_req,
    output logic [63:0] inst_addr,
    input  logic        inst_ack,
    input  logic [31:0] inst_rdata,
    input  logic        pc_jmp,
    input  logic [63:0] pc_jmpaddr,
    output logic [63:0] pc,
    output logic [31:0] inst,
    output logic [7:0]  instcycle_cnt_val,
    output logic        inst_commit,
    output logic        halted,
    output logic [1:0]  err_code
);

    typedef enum logic [1:0] {
        PH_IF = 2'd0,
        PH_ID = 2'd1,
        PH_EX = 2'd2,
        PH_WB = 2'd3
    } phase_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_MISALIGN = 2'b10;

    // Last wait-counter value at which a missing ack still gets one more chance.
    localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

    // Jump targets must be 32-bit word aligned.
    function automatic logic is_word_aligned(input logic [63:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

    phase_e      phase_q, phase_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [7:0]  wait_q, wait_d;
    logic        halted_q, halted_d;
    logic [1:0]  err_q, err_d;

    // Next-state logic: phase sequencing, fetch wait/timeout, WB redirect.
    always_comb begin
        phase_d  = phase_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        wait_d   = wait_q;
        halted_d = halted_q;
        err_d    = err_q;
        if (!halted_q) begin
            case (phase_q)
                PH_IF: begin
                    // req is high here (reset is handled in the register block).
                    if (inst_ack) begin
                        inst_d  = inst_rdata;
                        phase_d = PH_ID;
                        wait_d  = 8'd0;
                    end else begin
                        if (wait_q != 8'hFF) begin
                            wait_d = wait_q + 8'd1;
                        end else begin
                            wait_d = wait_q;
                        end
                        if (wait_q == TIMEOUT_LAST) begin
                            halted_d = 1'b1;
                            err_d    = ERR_TIMEOUT;
                        end else begin
                            halted_d = halted_q;
                        end
                    end
                end
                PH_ID: phase_d = PH_EX;
                PH_EX: phase_d = PH_WB;
                PH_WB: begin
                    phase_d = PH_IF;
                    if (pc_jmp) begin
                        // A misaligned target still retires this instruction,
                        // but the PC is left alone and the sequencer stops.
                        if (is_word_aligned(pc_jmpaddr)) begin
                            pc_d = pc_jmpaddr;
                        end else begin
                            halted_d = 1'b1;
                            err_d    = ERR_MISALIGN;
                        end
                    end else begin
                        pc_d = pc_q + 64'd4;
                    end
                end
                default: phase_d = PH_IF;
            endcase
        end else begin
            phase_d = phase_q;
        end
    end

    // State registers with synchronous reset; reset abandons any pending fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= PH_IF;
            pc_q     <= RESET_PC;
            inst_q   <= 32'd0;
            wait_q   <= 8'd0;
            halted_q <= 1'b0;
            err_q    <= ERR_NONE;
        end else begin
            phase_q  <= phase_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            wait_q   <= wait_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    assign inst_req          = (phase_q == PH_IF) & ~halted_q & ~rst;
    assign inst_commit       = (phase_q == PH_WB) & ~halted_q & ~rst;
    assign inst_addr         = pc_q;
    assign pc                = pc_q;
    assign inst              = inst_q;
    assign instcycle_cnt_val = {6'd0, phase_q};
    assign halted            = halted_q;
    assign err_code          = err_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Front end of the multi-cycle core: owns the PC and the instruction-cycle counter `instcycle_cnt_val` that paces the decode, execute and writeback stages.
- Fetches each instruction over a req/ack instruction-memory port.
- Consumes the registered redirect (`pc_jmp`/`pc_jmpaddr`) from the execute stage at the end of each instruction.
- Flags fetch timeouts and misaligned jump targets, and halts on either.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC value after reset.
- FETCH_TIMEOUT, 16, wait cycles allowed for inst_ack before a timeout error (valid range 1..255).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- inst_req  output  1  instruction fetch request
- inst_addr  output  64  fetch address; equals pc
- inst_ack  input  1  memory accepts the request; inst_rdata is valid in the same cycle
- inst_rdata  input  32  fetched instruction word
- pc_jmp  input  1  redirect request from execute; registered, valid while cnt==3
- pc_jmpaddr  input  64  redirect target; valid with pc_jmp
- pc  output  64  PC of the instruction in flight
- inst  output  32  latched instruction for decode
- instcycle_cnt_val  output  8  instruction-cycle phase: 0=IF, 1=ID, 2=EX, 3=WB
- inst_commit  output  1  one-cycle pulse in the WB phase of every retired instruction
- halted  output  1  sticky halt flag
- err_code  output  2  00 none, 01 fetch timeout, 10 misaligned jump; sticky

Behaviour:
- Reset (rst high at posedge): pc=RESET_PC, inst=0, cnt=0, wait counter=0, halted=0, err_code=00.
- During rst: inst_req=0 and inst_commit=0.
- inst_req is combinational: (cnt==0) & ~halted & ~rst.
- inst_addr is always pc.
- While inst_req is high, inst_addr is stable until ack.
- inst_ack is sampled only when inst_req is high. An ack with req low, including a late ack after reset or after halt, is ignored: no state change.
- Phase 0 (IF):
  - On an edge with req&ack: inst <= inst_rdata, cnt <= 1, wait counter <= 0.
  - Otherwise the wait counter increments (8-bit, saturating).
  - If the counter reaches FETCH_TIMEOUT-1 and no ack arrives on that edge: halted <= 1, err_code <= 01, cnt stays 0.
  - A same-cycle ack, including on the first req cycle, is legal: minimum IF latency is 1 cycle.
- Phase 1 goes to phase 2 unconditionally (1 cycle each). Phase 2 goes to phase 3 unconditionally (1 cycle each).
- Phase 3 (WB):
  - inst_commit=1 (combinational, cnt==3 & ~halted).
  - At the edge: cnt <= 0.
  - If pc_jmp=1 and pc_jmpaddr[1:0]==00: pc <= pc_jmpaddr.
  - If pc_jmp=1 and pc_jmpaddr[1:0]!=00: pc unchanged, halted <= 1, err_code <= 10. The instruction still counts as committed.
  - If pc_jmp=0: pc <= pc + 4 (64-bit, wraps modulo 2^64).
- Cycle cost: 3 + N cycles per instruction, where N ≥ 1 is the IF wait including the ack cycle. Back-to-back, req reasserts in the cycle right after phase 3.
- halted: freezes cnt, pc and inst; inst_req=0. Cleared only by rst.
- Reset mid-operation (any phase): all state returns to reset values at that edge. A pending fetch is abandoned; memory must tolerate req dropping without ack.
- pc_jmp/pc_jmpaddr are ignored in phases 0–2.

Test Plan:
- Reset then ack held high:
  - 1st cycle after reset: req=1, addr=0x8000_0000.
  - cnt sequence 0,1,2,3,0.
  - inst_commit pulses every 4 cycles.
  - 2nd fetch addr=0x8000_0004.
- Ack delayed 3 cycles with inst_rdata=0x00000013:
  - inst_req held 4 cycles, addr stable.
  - inst=0x13 latched.
  - cnt leaves 0 only on the ack edge.
- pc_jmp=1, pc_jmpaddr=0x8000_0100 in phase 3 → next inst_addr=0x8000_0100. With pc_jmp=0 in phase 3 → pc+4.
- pc_jmp=1, pc_jmpaddr=0x8000_0102:
  - commit pulse occurs.
  - then halted=1, err_code=10, pc unchanged.
  - inst_req stays 0 until rst.
- No ack, FETCH_TIMEOUT=16:
  - req high exactly 16 cycles.
  - then halted=1, err_code=01.
  - a later inst_ack=1 is ignored.
- rst asserted during the IF wait, then ack arrives on the cycle rst deasserts → ack ignored (req was 0). Refetch from 0x8000_0000 with req=1 the next cycle.
